my_ram_loader: RTL and testbench
================================

# my_ram_loader

Runtime-writable lookup table with a streaming load port and an asynchronous read port. Host-side or upstream logic streams `2**addr_bits` words through a valid/ready handshake after a `start` pulse. The block writes them to consecutive addresses from 0 and flags completion. Datapath logic reads the table combinationally by address. This lets emulator tables (impulse-response steps, DFE/CTLE coefficients) be reprogrammed without re-synthesis instead of being fixed at elaboration from a memory file.

## Interface
Parameters:
- `addr_bits`, default 1: table address width; table depth is `2**addr_bits` entries.
- `data_bits`, default 1: table word width.

Ports:
- `clk`  in  1  single clock for all sequential logic.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  single-cycle request to begin a full-table load.
- `in_data`  in  data_bits  load word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a word this cycle.
- `busy`  out  1  load in progress.
- `done`  out  1  sticky: the last completed load filled the whole table.
- `ovf`  out  1  sticky: `in_valid` was seen while not loading.
- `wr_count`  out  addr_bits+1  words accepted in the current or last load.
- `rd_addr`  in  addr_bits  read address.
- `rd_data`  out  data_bits  table word at `rd_addr`, combinational.

## Operation
- **Storage**
  - Array of `2**addr_bits` words of `data_bits` width.
  - Reset does not clear the array; contents survive reset.
  - Unwritten entries are undefined.
- **States:** IDLE, LOAD, DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready`=0, `busy`=0.
  - `start`=1 moves to LOAD and sets `wr_ptr`=0, `wr_count`=0, `done`=0, `ovf`=0.
- **LOAD**
  - `in_ready`=1, `busy`=1.
  - An accept happens when `in_valid`&&`in_ready` at the clock edge. On each accept: `mem[wr_ptr]`<=`in_data`, `wr_ptr`++, `wr_count`++.
  - An accept at `wr_ptr`==`2**addr_bits-1` moves to DONE. `wr_ptr` wraps to 0 and `wr_count` ends at `2**addr_bits`.
  - `start` in LOAD is ignored; there is no restart mid-load.
  - `in_valid`=0 stalls with no timeout; partial progress is held.
- **DONE**
  - `in_ready`=0, `busy`=0, `done`=1.
  - `start`=1 begins a new load exactly as from IDLE.
- **Overflow flag**
  - In IDLE or DONE, `in_valid`=1 sets `ovf`=1. The word is dropped and the array is unchanged.
  - `ovf` is cleared only by `start` or reset.
- **Simultaneous events**
  - `start` and `in_valid` in the same cycle in IDLE/DONE: the transition wins and `ovf` is not set. That word is not accepted because `in_ready`=0 that cycle.
- **Read port**
  - `rd_data` = `mem[rd_addr]` combinationally, with no reset dependency.
  - A read of the address being written returns the old word until the write edge and the new word after it.
- **Reset mid-load**
  - State goes to IDLE; `wr_ptr`, `wr_count`, `done`, `ovf` go to 0.
  - Words already written remain in the array.

## Timing
- Output reset values: `in_ready`=0, `busy`=0, `done`=0, `ovf`=0, `wr_count`=0. `rd_data` is not reset.
- `start` is sampled at edge N; `in_ready`/`busy` are high from cycle N+1.
- Each accepted word is visible on `rd_data` (with `rd_addr` pointing at it) in the cycle after its accept edge.
- The final accept at edge M sets `done`=1 and `in_ready`=0 in cycle M+1.
- Minimum full load is `1 + 2**addr_bits` cycles from `start` to `done`.
- `in_ready` depends only on state; there is no combinational path from `in_valid` to `in_ready`.
- All state and flag registers use asynchronous reset on the falling edge of `rst_n`. Release of `rst_n` is synchronous to `clk` by system convention.

## Test plan
Bench parameters: `addr_bits`=3, `data_bits`=8.
1. **Reset and idle**
   - Stimulus: assert `rst_n`=0, release, then drive `in_valid`=1 with `in_data`=0xAA for 1 cycle, no `start`.
   - Required: `in_ready`=0 throughout; `ovf`=1 afterwards; `done`=0; `wr_count`=0.
2. **Full load, back-to-back**
   - Stimulus: `start` pulse, then `in_valid`=1 continuously with `in_data`=0x10..0x17.
   - Required: exactly 8 accepts; `done`=1 at cycle 9 after `start`; `wr_count`=8; `rd_addr`=0..7 returns 0x10..0x17; `ovf`=0.
3. **Stalled load**
   - Stimulus: as scenario 2 but `in_valid` toggles 1,0,0,1,….
   - Required: `busy` holds through the gaps; words land at consecutive addresses with none lost or duplicated; `done` rises the cycle after the 8th accept.
4. **Ignored restart and extra words**
   - Stimulus: `start` again after 3 accepts, then finish the load, then keep `in_valid`=1 for 2 more cycles with `in_data`=0xFF.
   - Required: the restart has no effect; `done`=1; `ovf`=1; no address holds 0xFF.
5. **Reset mid-load**
   - Stimulus: load 0x20..0x24 (5 words), assert `rst_n`=0 asynchronously between edges, release.
   - Required: all outputs return to reset values immediately; `rd_addr`=0..4 still returns 0x20..0x24.
   - Follow-up: a new `start` plus 8 words 0x30..0x37 overwrites all entries.
6. **Read-during-write**
   - Stimulus: hold `rd_addr`=2 during a load that writes 0x55 to address 2.
   - Required: `rd_data` shows the old value up to the accept edge and 0x55 from the following cycle.

Source files
------------

// File: rtl/my_ram_loader_if.sv
// my_ram_loader_if: load-stream handshake, status flags and table read port for my_ram_loader
interface my_ram_loader_if #(
  parameter int addr_bits = 1,
  parameter int data_bits = 1
);
  logic                 start;
  logic [data_bits-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 busy;
  logic                 done;
  logic                 ovf;
  logic [addr_bits:0]   wr_count;
  logic [addr_bits-1:0] rd_addr;
  logic [data_bits-1:0] rd_data;
  modport master (
    output start, in_data, in_valid, rd_addr,
    input  in_ready, busy, done, ovf, wr_count, rd_data
  );
  modport slave (
    input  start, in_data, in_valid, rd_addr,
    output in_ready, busy, done, ovf, wr_count, rd_data
  );
endinterface

// File: rtl/my_ram_loader.sv
// my_ram_loader: runtime-writable table filled by a streamed full-table load, read combinationally
//   clk, rst_n      clock, async active-low reset (table contents survive reset)
//   bus.start       begin a full-table load from address 0
//   bus.in_*        load word stream (valid/ready)
//   bus.busy/done/ovf/wr_count  load status; done and ovf are sticky until the next start
//   bus.rd_addr/rd_data         asynchronous table read
module my_ram_loader #(
  parameter int addr_bits = 1,
  parameter int data_bits = 1
) (
  input logic            clk,
  input logic            rst_n,
  my_ram_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t               state_q, state_d;
  logic [addr_bits-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_bits:0]   wr_count_q, wr_count_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [data_bits-1:0] mem [2**addr_bits];
  logic                 accept;
  assign accept = bus.in_valid && state_q == LOAD;
  // start is only honoured outside LOAD, and it shadows a same-cycle in_valid so ovf stays clear
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_count_d = wr_count_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    if (state_q == LOAD) begin
      if (accept) begin
        wr_ptr_d   = wr_ptr_q + addr_bits'(1);
        wr_count_d = wr_count_q + (addr_bits + 1)'(1);
        state_d    = wr_ptr_q == '1 ? DONE : LOAD;
        done_d     = wr_ptr_q == '1;
      end
    end else if (bus.start) begin
      state_d    = LOAD;
      wr_ptr_d   = '0;
      wr_count_d = '0;
      done_d     = 1'b0;
      ovf_d      = 1'b0;
    end else if (bus.in_valid) begin
      ovf_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      wr_count_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_count_q <= wr_count_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= bus.in_data;
  end
  assign bus.in_ready = state_q == LOAD;
  assign bus.busy     = state_q == LOAD;
  assign bus.done     = done_q;
  assign bus.ovf      = ovf_q;
  assign bus.wr_count = wr_count_q;
  assign bus.rd_data  = mem[bus.rd_addr];
endmodule

// File: tb/tb_my_ram_loader.sv
// tb_my_ram_loader: directed vectors for my_ram_loader with addr_bits=3, data_bits=8
module tb_my_ram_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  my_ram_loader_if #(.addr_bits(3), .data_bits(8)) bus ();
  my_ram_loader #(.addr_bits(3), .data_bits(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rd_chk(input string tag, input int a, input logic [7:0] e);
    bus.rd_addr = 3'(a);
    #1;
    chk(tag, 32'(bus.rd_data), 32'(e));
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_ovf"}, 32'(bus.ovf), 0);
    chk({tag, "_cnt"}, 32'(bus.wr_count), 0);
  endtask
  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_ready", 32'(bus.in_ready), 1);
    chk("start_ovf", 32'(bus.ovf), 0);
    chk("start_done", 32'(bus.done), 0);
  endtask
  initial begin
    int k;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.rd_addr = '0;
    // reset and idle
    step();
    step();
    idle_chk("rst");
    rst_n = 1'b1;
    step();
    idle_chk("idle");
    bus.in_valid = 1'b1;
    bus.in_data = 8'hAA;
    step();
    chk("idle_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    chk("idle_ovf", 32'(bus.ovf), 1);
    chk("idle_done", 32'(bus.done), 0);
    chk("idle_cnt", 32'(bus.wr_count), 0);
    // back-to-back full load
    do_start();
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'h10 + i);
      step();
      chk("b2b_cnt", 32'(bus.wr_count), 32'(i + 1));
      chk("b2b_done", 32'(bus.done), 32'(i == 7));
      chk("b2b_busy", 32'(bus.busy), 32'(i != 7));
    end
    bus.in_valid = 1'b0;
    chk("b2b_ready", 32'(bus.in_ready), 0);
    chk("b2b_ovf", 32'(bus.ovf), 0);
    for (int i = 0; i < 8; i++) rd_chk("b2b_rd", i, 8'(8'h10 + i));
    // stalled load: valid pattern 1,0,0
    step();
    do_start();
    k = 0;
    for (int c = 0; c < 100 && k < 8; c++) begin
      bus.in_valid = (c % 3 == 0);
      bus.in_data = 8'(8'h40 + k);
      step();
      if (bus.in_valid) k++;
      chk("stall_busy", 32'(bus.busy), 32'(k < 8));
      chk("stall_done", 32'(bus.done), 32'(k == 8));
      chk("stall_cnt", 32'(bus.wr_count), 32'(k));
    end
    bus.in_valid = 1'b0;
    chk("stall_finished", 32'(k), 8);
    for (int i = 0; i < 8; i++) rd_chk("stall_rd", i, 8'(8'h40 + i));
    // ignored restart, then extra words after completion
    step();
    do_start();
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'h60 + i);
      bus.start = (i == 3);
      step();
      chk("rst_ign_cnt", 32'(bus.wr_count), 32'(i + 1));
    end
    bus.start = 1'b0;
    bus.in_data = 8'hFF;
    step();
    step();
    bus.in_valid = 1'b0;
    chk("extra_done", 32'(bus.done), 1);
    chk("extra_ovf", 32'(bus.ovf), 1);
    chk("extra_cnt", 32'(bus.wr_count), 8);
    for (int i = 0; i < 8; i++) rd_chk("extra_rd", i, 8'(8'h60 + i));
    // read-during-write on address 2 (old word is 0x62)
    bus.rd_addr = 3'd2;
    step();
    do_start();
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = (i == 2) ? 8'h55 : 8'(8'h50 + i);
      #3;
      chk("rdw_before", 32'(bus.rd_data), (i <= 2) ? 32'h62 : 32'h55);
      step();
      chk("rdw_after", 32'(bus.rd_data), (i >= 2) ? 32'h55 : 32'h62);
    end
    bus.in_valid = 1'b0;
    chk("rdw_done", 32'(bus.done), 1);
    // reset mid-load
    step();
    do_start();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'h20 + i);
      step();
    end
    bus.in_valid = 1'b0;
    chk("mid_cnt", 32'(bus.wr_count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    idle_chk("mid_rst");
    step();
    rst_n = 1'b1;
    step();
    idle_chk("mid_rel");
    for (int i = 0; i < 5; i++) rd_chk("mid_rd", i, 8'(8'h20 + i));
    for (int i = 5; i < 8; i++) rd_chk("mid_rd_old", i, 8'(8'h50 + i));
    do_start();
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'h30 + i);
      step();
    end
    bus.in_valid = 1'b0;
    chk("reload_done", 32'(bus.done), 1);
    chk("reload_cnt", 32'(bus.wr_count), 8);
    for (int i = 0; i < 8; i++) rd_chk("reload_rd", i, 8'(8'h30 + i));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
